// File: rtl/hand_pair_tracker.sv
// rtl/hand_pair_tracker.sv - two-stage left/right hand assignment with swap hysteresis, hold-over and smoothing
module hand_pair_tracker #(
  parameter int W            = 16,
  parameter int X_MID        = 320,
  parameter int DEAD_Y       = 320,
  parameter int SWAP_HYST    = 16,
  parameter int HOLD_FRAMES  = 4,
  parameter int SMOOTH_SHIFT = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] z1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] z2,
  input  logic         present1,
  input  logic         present2,
  output logic         out_valid,
  output logic [W-1:0] left_x,
  output logic [W-1:0] left_y,
  output logic [W-1:0] left_z,
  output logic [W-1:0] right_x,
  output logic [W-1:0] right_y,
  output logic [W-1:0] right_z,
  output logic         left_ok,
  output logic         right_ok,
  output logic         swapped
);

  localparam int CW = $clog2(HOLD_FRAMES + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_OK  = CW'(HOLD_FRAMES);

  // tracking state
  logic          swap_r, prior_r;
  logic [CW-1:0] lcnt_r, rcnt_r;

  // stage-1 pipeline registers
  logic          s1_valid, s1_lp, s1_rp, s1_lok, s1_rok, s1_swap;
  logic [W-1:0]  s1_lx, s1_ly, s1_lz, s1_rx, s1_ry, s1_rz;

  // stage-1 combinational results
  logic          raw_swap, dead1, dead2;
  logic [W:0]    dx, adx;
  logic [W-1:0]  ya, yb;
  logic          swap_n, prior_n, lp, rp, lok_n, rok_n;
  logic [CW-1:0] lcnt_n, rcnt_n;
  logic [W-1:0]  lx, ly, lz, rx, ry, rz;

  always_comb begin
    raw_swap = x1 > x2;
    dx       = {1'b0, x1} - {1'b0, x2};
    adx      = dx[W] ? (~dx + 1'b1) : dx;
    dead1    = y1 >= W'(DEAD_Y);
    dead2    = y2 >= W'(DEAD_Y);
    ya       = y1;
    yb       = y2;
    swap_n   = swap_r;
    prior_n  = prior_r;
    lp       = 1'b0;
    rp       = 1'b0;
    lx = '0; ly = '0; lz = '0;
    rx = '0; ry = '0; rz = '0;

    if (present1 && present2) begin
      if (!prior_r)
        swap_n = raw_swap;
      else if ((raw_swap != swap_r) && (adx > (W+1)'(SWAP_HYST)))
        swap_n = raw_swap;
      prior_n = 1'b1;
      // a single hand low in the frame borrows its partner's height
      if (dead1 && !dead2)
        ya = y2;
      else if (dead2 && !dead1)
        yb = y1;
      lp = 1'b1;
      rp = 1'b1;
      if (swap_n) begin
        lx = x2; ly = yb; lz = z2;
        rx = x1; ry = ya; rz = z1;
      end else begin
        lx = x1; ly = ya; lz = z1;
        rx = x2; ry = yb; rz = z2;
      end
    end else if (present1) begin
      if (x1 < W'(X_MID)) begin
        lp = 1'b1; lx = x1; ly = y1; lz = z1;
      end else begin
        rp = 1'b1; rx = x1; ry = y1; rz = z1;
      end
    end else if (present2) begin
      if (x2 < W'(X_MID)) begin
        lp = 1'b1; lx = x2; ly = y2; lz = z2;
      end else begin
        rp = 1'b1; rx = x2; ry = y2; rz = z2;
      end
    end

    lcnt_n = lp ? '0 : ((lcnt_r == CNT_SAT) ? CNT_SAT : lcnt_r + 1'b1);
    rcnt_n = rp ? '0 : ((rcnt_r == CNT_SAT) ? CNT_SAT : rcnt_r + 1'b1);
    lok_n  = lcnt_n <= CNT_OK;
    rok_n  = rcnt_n <= CNT_OK;
    if (!lok_n && !rok_n)
      prior_n = 1'b0;
  end

  // sides start out lost so ok stays low until a hand is actually seen
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      swap_r   <= 1'b0;
      prior_r  <= 1'b0;
      lcnt_r   <= CNT_SAT;
      rcnt_r   <= CNT_SAT;
      s1_valid <= 1'b0;
      s1_lp    <= 1'b0;
      s1_rp    <= 1'b0;
      s1_lok   <= 1'b0;
      s1_rok   <= 1'b0;
      s1_swap  <= 1'b0;
      s1_lx <= '0; s1_ly <= '0; s1_lz <= '0;
      s1_rx <= '0; s1_ry <= '0; s1_rz <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        swap_r  <= swap_n;
        prior_r <= prior_n;
        lcnt_r  <= lcnt_n;
        rcnt_r  <= rcnt_n;
        s1_lp   <= lp;
        s1_rp   <= rp;
        s1_lok  <= lok_n;
        s1_rok  <= rok_n;
        s1_swap <= swap_n;
        s1_lx <= lx; s1_ly <= ly; s1_lz <= lz;
        s1_rx <= rx; s1_ry <= ry; s1_rz <= rz;
      end
    end
  end

  function automatic logic [W-1:0] smooth(input logic [W-1:0] cur, input logic [W-1:0] nw);
    logic signed [W:0] d;
    d = $signed({1'b0, nw}) - $signed({1'b0, cur});
    d = d >>> SMOOTH_SHIFT;
    return cur + d[W-1:0];
  endfunction

  // a side that was not ok on the previous update reloads instead of filtering
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      left_ok   <= 1'b0;
      right_ok  <= 1'b0;
      swapped   <= 1'b0;
      left_x  <= '0; left_y  <= '0; left_z  <= '0;
      right_x <= '0; right_y <= '0; right_z <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        left_ok  <= s1_lok;
        right_ok <= s1_rok;
        swapped  <= s1_swap;
        if (s1_lp) begin
          left_x <= left_ok ? smooth(left_x, s1_lx) : s1_lx;
          left_y <= left_ok ? smooth(left_y, s1_ly) : s1_ly;
          left_z <= left_ok ? smooth(left_z, s1_lz) : s1_lz;
        end
        if (s1_rp) begin
          right_x <= right_ok ? smooth(right_x, s1_rx) : s1_rx;
          right_y <= right_ok ? smooth(right_y, s1_ry) : s1_ry;
          right_z <= right_ok ? smooth(right_z, s1_rz) : s1_rz;
        end
      end
    end
  end

endmodule
